// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains a registered-read Fifo into a valid/ready stream via a 2-entry skid buffer
//
// Optional feature macro: FIFO_READER_BURST_EN (burst-gated reads; default build reads whenever data exists)
//
// Ports:
//   clk, rst_b       clock, asynchronous active-low reset
//   fifo_empty       Fifo empty flag
//   fifo_available   Fifo word count (used only by the burst gate)
//   fifo_rd_dat      Fifo read data, valid the cycle after fifo_rd_en
//   fifo_rd_en       Fifo pop strobe (combinational, forced low in reset)
//   out_valid        stream word valid (registered)
//   out_ready        stream consumer accepts
//   out_data         stream word, head of the skid buffer (registered)
//   buf_count        words held in the skid buffer (0..2)
module fifo_stream_reader #(
    parameter int WIDTH        = 8,
    parameter int AVAIL_W      = 5,
    parameter int BURST_MIN    = 4,
    parameter int FLUSH_CYCLES = 15
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               fifo_empty,
    input  logic [AVAIL_W-1:0] fifo_available,
    input  logic [WIDTH-1:0]   fifo_rd_dat,
    output logic               fifo_rd_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         buf_count
);

    logic             inflight;
    logic [WIDTH-1:0] tail_data;
    logic             pop;
    logic             gate;
    logic [2:0]       occ_next;

    assign pop = out_valid & out_ready;

    // Occupancy after this edge, counting the word already requested from the
    // Fifo. Keeping this below 2 before issuing a read guarantees a slot for
    // every captured word, so the buffer can never overflow.
    assign occ_next = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};

    assign fifo_rd_en = rst_b & ~fifo_empty & gate & (occ_next < 3'd2);

`ifdef FIFO_READER_BURST_EN
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam int CNT_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [31:0]        avail_ext;

    assign avail_ext = {{(32-AVAIL_W){1'b0}}, fifo_available};
    assign gate      = (state == DRAIN);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A partial fill still drains once it has waited long enough.
                    if (avail_ext >= 32'(BURST_MIN) || wait_cnt == CNT_W'(FLUSH_CYCLES)) begin
                        state    <= DRAIN;
                        wait_cnt <= '0;
                    end else if (fifo_empty) begin
                        wait_cnt <= '0;
                    end else if (wait_cnt != CNT_W'(FLUSH_CYCLES)) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    wait_cnt <= '0;
                    if (fifo_empty && !fifo_rd_en) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end
`else
    localparam int UNUSED_CFG = BURST_MIN + FLUSH_CYCLES;
    logic unused_avail;

    assign unused_avail = ^fifo_available;
    assign gate         = 1'b1;
`endif

    // out_data doubles as the head entry; tail_data is the second slot.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            inflight  <= 1'b0;
            buf_count <= 2'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            tail_data <= '0;
        end else begin
            inflight  <= fifo_rd_en;
            buf_count <= occ_next[1:0];
            out_valid <= (occ_next != 3'd0);
            if (pop) begin
                if (buf_count == 2'd2) begin
                    out_data <= tail_data;
                    if (inflight) begin
                        tail_data <= fifo_rd_dat;
                    end
                end else if (inflight) begin
                    out_data <= fifo_rd_dat;
                end
            end else if (inflight) begin
                if (buf_count == 2'd0) begin
                    out_data <= fifo_rd_dat;
                end else begin
                    tail_data <= fifo_rd_dat;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - scoreboard testbench for fifo_stream_reader with a behavioural Fifo
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [4:0]  fifo_available = 5'd0;
    logic [7:0]  fifo_rd_dat = 8'd0;
    logic        fifo_rd_en;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [1:0]  buf_count;

    logic [7:0]  fifo_q[$];
    logic [7:0]  exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          pop_count = 0;
    int          p0;
    logic        inflight_m;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'd0;

    fifo_stream_reader dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .fifo_empty     (fifo_empty),
        .fifo_available (fifo_available),
        .fifo_rd_dat    (fifo_rd_dat),
        .fifo_rd_en     (fifo_rd_en),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .buf_count      (buf_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        fifo_q.push_back(d);
        exp_q.push_back(d);
    endtask

    // Behavioural Fifo: registered read data, flags refreshed just after each edge.
    always @(posedge clk) begin
        if (rst_b && fifo_rd_en) begin
            if (fifo_q.size() == 0) check("rd_on_empty", 32'd1, 32'd0);
            else fifo_rd_dat <= fifo_q.pop_front();
        end
        #2;
        fifo_empty     = (fifo_q.size() == 0);
        fifo_available = 5'(fifo_q.size());
    end

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) inflight_m <= 1'b0;
        else        inflight_m <= fifo_rd_en;
    end

    // Scoreboard monitor: compares every accepted word and watches stalls.
    always @(negedge clk) begin
        if (rst_b) begin
            check("no_overflow", 32'(inflight_m && buf_count == 2'd2 && !(out_valid && out_ready)), 32'd0);
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && out_ready) begin
                pop_count++;
                if (exp_q.size() == 0) check("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
                else check("order", 32'(out_data), 32'(exp_q.pop_front()));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        rst_b = 1'b1;

        // Idle with empty Fifo
        repeat (10) begin
            @(negedge clk);
            check("idle_valid", 32'(out_valid), 32'd0);
            check("idle_rd_en", 32'(fifo_rd_en), 32'd0);
            check("idle_count", 32'(buf_count), 32'd0);
        end

`ifndef FIFO_READER_BURST_EN
        // Latency and back-to-back throughput
        tick();
        out_ready = 1'b1;
        push(8'd1); push(8'd2); push(8'd3);
        @(negedge clk);
        check("lat0_valid", 32'(out_valid), 32'd0);
        check("lat0_rd_en", 32'(fifo_rd_en), 32'd1);
        @(negedge clk);
        check("lat1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat2_valid", 32'(out_valid), 32'd1);
        check("lat2_data", 32'(out_data), 32'd1);
        #1;
        p0 = pop_count;
        repeat (2) @(negedge clk);
        #1;
        check("burst3_gapless", 32'(pop_count - p0), 32'd2);
        repeat (3) tick();

        // Backpressure fills the skid buffer, then drains without gaps
        out_ready = 1'b0;
        for (int i = 4; i <= 9; i++) push(8'(i));
        repeat (8) tick();
        @(negedge clk);
        check("bp_count", 32'(buf_count), 32'd2);
        check("bp_rd_en", 32'(fifo_rd_en), 32'd0);
        check("bp_avail", 32'(fifo_available), 32'd4);
        check("bp_head", 32'(out_data), 32'd4);
        tick();
        out_ready = 1'b1;
        p0 = pop_count;
        repeat (6) @(negedge clk);
        #1;
        check("bp_gapless", 32'(pop_count - p0), 32'd6);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Alternating ready
        p0 = pop_count;
        for (int i = 10; i <= 17; i++) push(8'(i));
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            tick();
            out_ready = ~out_ready;
        end
        check("toggle_drained", 32'(exp_q.size()), 32'd0);
        check("toggle_pops", 32'(pop_count - p0), 32'd8);
        tick();
        out_ready = 1'b1;
        repeat (3) tick();

        // Asynchronous reset with a full buffer
        out_ready = 1'b0;
        for (int i = 20; i <= 25; i++) push(8'(i));
        repeat (6) tick();
        @(negedge clk);
        check("pre_rst_count", 32'(buf_count), 32'd2);
        #2;
        rst_b = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(buf_count), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        fifo_q.delete();
        exp_q.delete();
        repeat (2) tick();
        rst_b = 1'b1;
        out_ready = 1'b1;
        push(8'd30);
        repeat (6) tick();
        check("post_rst_drained", 32'(exp_q.size()), 32'd0);
`else
        // Partial fill waits for the flush timer
        out_ready = 1'b1;
        tick();
        push(8'd1); push(8'd2); push(8'd3);
        repeat (16) begin
            @(negedge clk);
            check("flush_hold", 32'(out_valid), 32'd0);
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("flush_drained", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();

        // Reaching BURST_MIN starts the drain on the next cycle
        push(8'd4); push(8'd5); push(8'd6); push(8'd7);
        @(negedge clk);
        check("burst_n0_rd_en", 32'(fifo_rd_en), 32'd0);
        @(negedge clk);
        check("burst_n1_rd_en", 32'(fifo_rd_en), 32'd1);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("burst_drained", 32'(exp_q.size()), 32'd0);
`endif

        repeat (3) tick();
        check("final_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
